// File: rtl/seg7_pkg.sv
// Shared BCD and seven-segment types, segment constants and the digit pattern table.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'h7F;
    localparam seg7_t SEG_DASH  = 7'b0111111;

    localparam seg7_t SEG_TABLE [10] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000   // 9
    };

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder.
// Codes 10-15 are not valid BCD and show a dash.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        if (bcd < 4'd10) begin
            seg = SEG_TABLE[bcd];
        end
    end

endmodule

// File: rtl/bcd_digit_scanner.sv
// Scans N BCD digits onto one common-anode display: one slot per digit, slot cycle 0 dark.
// Outputs are registered one cycle after cnt/idx/snap; no flow control, free-running.
// Optional LEADING_ZERO_BLANK_EN suppresses the segments of leading zero digits.
module bcd_digit_scanner
    import seg7_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int PRESCALE = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*N_DIGITS-1:0] digits,
    output logic [6:0]            seg,
    output logic [N_DIGITS-1:0]   an
);

    localparam int CW = $clog2(PRESCALE);
    localparam int IW = $clog2(N_DIGITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    bcd_t                  snap [N_DIGITS];
    bcd_t                  cur;
    seg7_t                 dec_seg;
    seg7_t                 seg_next;
    logic [N_DIGITS-1:0]   an_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Whole-frame snapshot at the start of digit 0's slot keeps a frame from showing a torn count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                snap[i] <= '0;
            end
        end else if (cnt == '0 && idx == '0) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                snap[i] <= digits[4*i +: 4];
            end
        end
    end

    assign cur = snap[idx];

    bcd_to_seg7 u_dec (
        .bcd (cur),
        .seg (dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [N_DIGITS-1:0] lz;
    logic                run;

    // lz[i]: digit i and every more significant digit are zero; digit 0 always shows.
    always_comb begin
        lz  = '0;
        run = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            run   = run & (snap[i] == 4'd0);
            lz[i] = run;
        end
    end
`endif

    always_comb begin
        seg_next = SEG_BLANK;
        an_next  = '1;
        if (cnt != '0) begin
            an_next[idx] = 1'b0;
            seg_next     = dec_seg;
`ifdef LEADING_ZERO_BLANK_EN
            if (lz[idx]) begin
                seg_next = SEG_BLANK;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg <= SEG_BLANK;
            an  <= '1;
        end else begin
            seg <= seg_next;
            an  <= an_next;
        end
    end

endmodule
